scaler_out_collector: RTL and testbench

SCALER_OUT_COLLECTOR -- requirements
Module: scaler_out_collector

---
 rtl/scaler_pkg.sv | 18 +
 rtl/scaler_out_fifo.sv | 65 ++++++
 rtl/scaler_out_collector.sv | 143 ++++++++++++++
 tb/tb_scaler_out_collector.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/scaler_pkg.sv
// Shared state encoding and pixel FIFO entry layout for the scaler output collector.
package scaler_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_COLLECT = 2'd1,
    ST_DRAIN   = 2'd2,
    ST_DONE    = 2'd3
  } state_e;

  // FIFO entry is {pixel, sof, eol}; eol sits in bit 0.
  localparam int unsigned ENTRY_EOL_BIT = 0;
  localparam int unsigned ENTRY_SOF_BIT = 1;
  localparam int unsigned ENTRY_PIX_LSB = 2;

  localparam int unsigned DROP_COUNT_W = 16;

endpackage

// File: rtl/scaler_out_fifo.sv
// Single-clock show-ahead FIFO with count-based full/empty; a write into a full FIFO
// is accepted only when a read retires an entry on the same edge.
module scaler_out_fifo #(
  parameter int unsigned WIDTH = 26,
  parameter int unsigned DEPTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush_i,
  input  logic             wr_en_i,
  input  logic [WIDTH-1:0] wr_data_i,
  input  logic             rd_en_i,
  output logic [WIDTH-1:0] rd_data_o,
  output logic             empty_o,
  output logic             drop_o
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [AW:0]      count_q, count_d;
  logic             full, do_wr, do_rd;

  assign empty_o = (count_q == '0);
  assign full    = (count_q == (AW+1)'(DEPTH));
  assign do_rd   = rd_en_i && !empty_o;
  assign do_wr   = wr_en_i && (!full || do_rd);
  assign drop_o  = wr_en_i && !do_wr;

  // Zero when empty, so the output reads 0 after reset without clearing storage.
  assign rd_data_o = empty_o ? '0 : mem[rd_ptr_q];

  // NOTE: combinational blocks use blocking '=' with a default first; clocked state uses '<='.
  always_comb begin
    count_d = count_q;
    case ({do_wr, do_rd})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else if (flush_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_wr) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_rd) rd_ptr_q <= rd_ptr_q + 1'b1;
      count_q <= count_d;
    end
  end

  // NOTE: the storage array is deliberately not reset; validity comes from count_q alone.
  always_ff @(posedge clk) begin
    if (do_wr && !flush_i) mem[wr_ptr_q] <= wr_data_i;
  end

endmodule

// File: rtl/scaler_out_collector.sv
// Collects scaled pixels into a FIFO tagged with sof/eol and hands them downstream.
// Optional drop statistics enabled by defining SCALER_COLLECT_STATS_EN.
module scaler_out_collector
  import scaler_pkg::*;
#(
  parameter int unsigned DATA_WIDTH         = 8,
  parameter int unsigned CHANNELS           = 3,
  parameter int unsigned OUTPUT_X_RES_WIDTH = 11,
  parameter int unsigned OUTPUT_Y_RES_WIDTH = 11,
  parameter int unsigned FIFO_DEPTH         = 16
) (
  input  logic                           clk_fast,
  input  logic                           rst_n,
  input  logic                           start,
  input  logic [OUTPUT_X_RES_WIDTH-1:0]  outputXRes,
  input  logic [OUTPUT_Y_RES_WIDTH-1:0]  outputYRes,
  input  logic [DATA_WIDTH*CHANNELS-1:0] dOut,
  input  logic                           dOutValid,
  output logic [DATA_WIDTH*CHANNELS-1:0] pxOut,
  output logic                           pxValid,
  input  logic                           pxReady,
  output logic                           pxSof,
  output logic                           pxEol,
  output logic                           frameDone,
  output logic                           overflow,
  output logic [DROP_COUNT_W-1:0]        dropCount
);

  localparam int unsigned PIX_W   = DATA_WIDTH * CHANNELS;
  localparam int unsigned ENTRY_W = PIX_W + ENTRY_PIX_LSB;

  state_e                        state_q, state_d;
  logic [OUTPUT_X_RES_WIDTH-1:0] col_q, xres_q;
  logic [OUTPUT_Y_RES_WIDTH-1:0] line_q, yres_q;
  logic                          overflow_q;
  logic                          push_req, last_col, last_px, pop;
  logic                          fifo_empty, fifo_drop;
  logic [ENTRY_W-1:0]            wr_entry, rd_entry;

  assign last_col = (col_q == xres_q);
  assign last_px  = last_col && (line_q == yres_q);
  // start wins over a same-cycle pixel: the flush must not race a write.
  assign push_req = (state_q == ST_COLLECT) && dOutValid && !start;
  assign pop      = pxValid && pxReady;

  always_comb begin
    wr_entry                             = '0;
    wr_entry[ENTRY_PIX_LSB +: PIX_W]     = dOut;
    wr_entry[ENTRY_SOF_BIT]              = (col_q == '0) && (line_q == '0);
    wr_entry[ENTRY_EOL_BIT]              = last_col;
  end

  scaler_out_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk_fast),
    .rst_n     (rst_n),
    .flush_i   (start),
    .wr_en_i   (push_req),
    .wr_data_i (wr_entry),
    .rd_en_i   (pop),
    .rd_data_o (rd_entry),
    .empty_o   (fifo_empty),
    .drop_o    (fifo_drop)
  );

  assign pxValid = !fifo_empty;
  assign pxOut   = rd_entry[ENTRY_PIX_LSB +: PIX_W];
  assign pxSof   = rd_entry[ENTRY_SOF_BIT];
  assign pxEol   = rd_entry[ENTRY_EOL_BIT];

  always_comb begin
    state_d   = state_q;
    frameDone = 1'b0;
    if (start) begin
      state_d = ST_COLLECT;
    end else begin
      case (state_q)
        ST_COLLECT: if (push_req && last_px) state_d = ST_DRAIN;
        ST_DRAIN: begin
          if (fifo_empty) begin
            state_d   = ST_DONE;
            frameDone = 1'b1;
          end
        end
        default: state_d = state_q;
      endcase
    end
  end

  always_ff @(posedge clk_fast or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      col_q      <= '0;
      line_q     <= '0;
      xres_q     <= '0;
      yres_q     <= '0;
      overflow_q <= 1'b0;
    end else begin
      state_q <= state_d;
      if (start) begin
        col_q      <= '0;
        line_q     <= '0;
        xres_q     <= outputXRes;
        yres_q     <= outputYRes;
        overflow_q <= 1'b0;
      end else begin
        // Geometry advances even on a dropped pixel so sof/eol stay aligned.
        if (push_req) begin
          if (last_col) begin
            col_q <= '0;
            if (line_q != yres_q) line_q <= line_q + 1'b1;
          end else begin
            col_q <= col_q + 1'b1;
          end
        end
        if (fifo_drop) overflow_q <= 1'b1;
      end
    end
  end

  assign overflow = overflow_q;

`ifdef SCALER_COLLECT_STATS_EN
  logic [DROP_COUNT_W-1:0] drop_cnt_q;

  always_ff @(posedge clk_fast or negedge rst_n) begin
    if (!rst_n) begin
      drop_cnt_q <= '0;
    end else if (start) begin
      drop_cnt_q <= '0;
    end else if (fifo_drop && (drop_cnt_q != '1)) begin
      drop_cnt_q <= drop_cnt_q + 1'b1;
    end
  end

  assign dropCount = drop_cnt_q;
`else
  assign dropCount = '0;
`endif

endmodule

// File: tb/tb_scaler_out_collector.sv
// Directed bench for scaler_out_collector (FIFO_DEPTH=4, 4x2 frame).
module tb_scaler_out_collector;

  localparam int DW    = 8;
  localparam int CH    = 3;
  localparam int XW    = 11;
  localparam int YW    = 11;
  localparam int DEPTH = 4;
  localparam int PW    = DW * CH;

`ifdef SCALER_COLLECT_STATS_EN
  localparam logic [15:0] EXP_DROP4 = 16'd4;
`else
  localparam logic [15:0] EXP_DROP4 = 16'd0;
`endif

  logic          clk_fast   = 1'b0;
  logic          rst_n      = 1'b1;
  logic          start      = 1'b0;
  logic [XW-1:0] outputXRes = 11'd3;
  logic [YW-1:0] outputYRes = 11'd1;
  logic [PW-1:0] dOut       = '0;
  logic          dOutValid  = 1'b0;
  logic          pxReady    = 1'b0;
  logic [PW-1:0] pxOut;
  logic          pxValid, pxSof, pxEol, frameDone, overflow;
  logic [15:0]   dropCount;

  int n_cmp = 0;
  int n_bad = 0;

  scaler_out_collector #(
    .DATA_WIDTH         (DW),
    .CHANNELS           (CH),
    .OUTPUT_X_RES_WIDTH (XW),
    .OUTPUT_Y_RES_WIDTH (YW),
    .FIFO_DEPTH         (DEPTH)
  ) dut (
    .clk_fast   (clk_fast),
    .rst_n      (rst_n),
    .start      (start),
    .outputXRes (outputXRes),
    .outputYRes (outputYRes),
    .dOut       (dOut),
    .dOutValid  (dOutValid),
    .pxOut      (pxOut),
    .pxValid    (pxValid),
    .pxReady    (pxReady),
    .pxSof      (pxSof),
    .pxEol      (pxEol),
    .frameDone  (frameDone),
    .overflow   (overflow),
    .dropCount  (dropCount)
  );

  always #5 clk_fast = ~clk_fast;

  function automatic logic [PW-1:0] pix(input int i);
    return PW'(32'hA00000 + i);
  endfunction

  // Inputs change at the falling edge, after that edge's outputs were sampled.
  task automatic pulse_start();
    start     = 1'b1;
    dOutValid = 1'b0;
    @(negedge clk_fast);
    start = 1'b0;
  endtask

  task automatic test_reset();
    #1 rst_n = 1'b0;
    #2;
    n_cmp++; if (pxValid !== 1'b0)  begin n_bad++; $display("FAIL reset_pxValid: got %b want 0", pxValid); end
    n_cmp++; if (pxOut !== '0)      begin n_bad++; $display("FAIL reset_pxOut: got %h want 0", pxOut); end
    n_cmp++; if ({pxSof, pxEol, frameDone, overflow} !== 4'b0)
      begin n_bad++; $display("FAIL reset_flags: got %b want 0000", {pxSof, pxEol, frameDone, overflow}); end
    n_cmp++; if (dropCount !== 16'd0) begin n_bad++; $display("FAIL reset_dropCount: got %0d want 0", dropCount); end
    @(negedge clk_fast);
    rst_n = 1'b1;
    // IDLE ignores pixels entirely.
    dOutValid = 1'b1; dOut = pix(77); pxReady = 1'b1;
    repeat (3) @(negedge clk_fast);
    n_cmp++; if (pxValid !== 1'b0)  begin n_bad++; $display("FAIL idle_ignore_pxValid: got %b want 0", pxValid); end
    n_cmp++; if (overflow !== 1'b0) begin n_bad++; $display("FAIL idle_ignore_overflow: got %b want 0", overflow); end
    dOutValid = 1'b0;
  endtask

  task automatic test_basic_frame();
    int pops = 0, dones = 0, sent = 0;
    outputXRes = 11'd3; outputYRes = 11'd1; pxReady = 1'b1;
    pulse_start();
    for (int c = 0; c < 30; c++) begin
      if (pxValid && pxReady) begin
        n_cmp++; if (pxOut !== pix(pops)) begin n_bad++; $display("FAIL basic_px%0d: got %h want %h", pops, pxOut, pix(pops)); end
        n_cmp++; if (pxSof !== (pops == 0)) begin n_bad++; $display("FAIL basic_sof%0d: got %b want %b", pops, pxSof, pops == 0); end
        n_cmp++; if (pxEol !== (pops == 3 || pops == 7))
          begin n_bad++; $display("FAIL basic_eol%0d: got %b want %b", pops, pxEol, pops == 3 || pops == 7); end
        pops++;
      end
      if (frameDone) dones++;
      if (sent < 8) begin dOutValid = 1'b1; dOut = pix(sent); sent++; end
      else dOutValid = 1'b0;
      @(negedge clk_fast);
    end
    n_cmp++; if (pops != 8)  begin n_bad++; $display("FAIL basic_pop_count: got %0d want 8", pops); end
    n_cmp++; if (dones != 1) begin n_bad++; $display("FAIL basic_frameDone_count: got %0d want 1", dones); end
    n_cmp++; if (overflow !== 1'b0) begin n_bad++; $display("FAIL basic_overflow: got %b want 0", overflow); end
  endtask

  task automatic test_overflow();
    int pops = 0, dones = 0, pops_at_done = -1;
    pxReady = 1'b0;
    pulse_start();
    for (int i = 0; i < 8; i++) begin
      if (pxValid) begin
        n_cmp++; if (pxOut !== pix(0)) begin n_bad++; $display("FAIL ovf_stall_stable: got %h want %h", pxOut, pix(0)); end
      end
      dOutValid = 1'b1; dOut = pix(i);
      @(negedge clk_fast);
    end
    dOutValid = 1'b0;
    @(negedge clk_fast);
    n_cmp++; if (overflow !== 1'b1)     begin n_bad++; $display("FAIL ovf_flag: got %b want 1", overflow); end
    n_cmp++; if (dropCount !== EXP_DROP4) begin n_bad++; $display("FAIL ovf_dropCount: got %0d want %0d", dropCount, EXP_DROP4); end
    n_cmp++; if (frameDone !== 1'b0)    begin n_bad++; $display("FAIL ovf_early_done: got %b want 0", frameDone); end
    pxReady = 1'b1;
    for (int c = 0; c < 20; c++) begin
      if (pxValid && pxReady) begin
        n_cmp++; if (pxOut !== pix(pops)) begin n_bad++; $display("FAIL ovf_px%0d: got %h want %h", pops, pxOut, pix(pops)); end
        n_cmp++; if (pxEol !== (pops == 3)) begin n_bad++; $display("FAIL ovf_eol%0d: got %b want %b", pops, pxEol, pops == 3); end
        pops++;
      end
      if (frameDone) begin dones++; pops_at_done = pops; end
      @(negedge clk_fast);
    end
    n_cmp++; if (pops != 4)         begin n_bad++; $display("FAIL ovf_pop_count: got %0d want 4", pops); end
    n_cmp++; if (dones != 1)        begin n_bad++; $display("FAIL ovf_frameDone_count: got %0d want 1", dones); end
    n_cmp++; if (pops_at_done != 4) begin n_bad++; $display("FAIL ovf_done_after_drain: got %0d want 4", pops_at_done); end
    n_cmp++; if (overflow !== 1'b1) begin n_bad++; $display("FAIL ovf_sticky: got %b want 1", overflow); end
  endtask

  task automatic test_full_push_pop();
    int pops = 0;
    pxReady = 1'b0;
    pulse_start();
    for (int i = 0; i < 4; i++) begin
      dOutValid = 1'b1; dOut = pix(10 + i);
      @(negedge clk_fast);
    end
    dOutValid = 1'b1; dOut = pix(14); pxReady = 1'b1;
    @(negedge clk_fast);
    dOutValid = 1'b0; pxReady = 1'b0;
    n_cmp++; if (overflow !== 1'b0) begin n_bad++; $display("FAIL fullpp_overflow: got %b want 0", overflow); end
    n_cmp++; if (dropCount !== 16'd0) begin n_bad++; $display("FAIL fullpp_dropCount: got %0d want 0", dropCount); end
    n_cmp++; if (pxOut !== pix(11)) begin n_bad++; $display("FAIL fullpp_head: got %h want %h", pxOut, pix(11)); end
    pxReady = 1'b1;
    for (int c = 0; c < 8; c++) begin
      if (pxValid && pxReady) begin
        n_cmp++; if (pxOut !== pix(11 + pops)) begin n_bad++; $display("FAIL fullpp_px%0d: got %h want %h", pops, pxOut, pix(11 + pops)); end
        pops++;
      end
      @(negedge clk_fast);
    end
    n_cmp++; if (pops != 4) begin n_bad++; $display("FAIL fullpp_pop_count: got %0d want 4", pops); end
  endtask

  task automatic test_restart();
    pxReady = 1'b0;
    pulse_start();
    for (int i = 0; i < 5; i++) begin
      dOutValid = 1'b1; dOut = pix(20 + i);
      @(negedge clk_fast);
    end
    pulse_start();
    n_cmp++; if (pxValid !== 1'b0)    begin n_bad++; $display("FAIL restart_flush: got %b want 0", pxValid); end
    n_cmp++; if (overflow !== 1'b0)   begin n_bad++; $display("FAIL restart_overflow: got %b want 0", overflow); end
    n_cmp++; if (dropCount !== 16'd0) begin n_bad++; $display("FAIL restart_dropCount: got %0d want 0", dropCount); end
    dOutValid = 1'b1; dOut = 24'h55AA33;
    @(negedge clk_fast);
    dOutValid = 1'b0;
    n_cmp++; if (pxValid !== 1'b1)     begin n_bad++; $display("FAIL restart_latency: got %b want 1", pxValid); end
    n_cmp++; if (pxOut !== 24'h55AA33) begin n_bad++; $display("FAIL restart_px: got %h want 55aa33", pxOut); end
    n_cmp++; if ({pxSof, pxEol} !== 2'b10) begin n_bad++; $display("FAIL restart_sof_eol: got %b want 10", {pxSof, pxEol}); end
  endtask

  task automatic test_done_ignore();
    int dones = 0, leaks = 0;
    pxReady = 1'b1;
    pulse_start();
    for (int c = 0; c < 30 && dones == 0; c++) begin
      if (frameDone) dones++;
      dOutValid = (c < 8); dOut = pix(40 + c);
      @(negedge clk_fast);
    end
    n_cmp++; if (dones != 1) begin n_bad++; $display("FAIL done_reached: got %0d pulses want 1", dones); end
    for (int c = 0; c < 6; c++) begin
      if (pxValid || frameDone || overflow) leaks++;
      dOutValid = c[0]; dOut = pix(99);
      @(negedge clk_fast);
    end
    dOutValid = 1'b0;
    n_cmp++; if (leaks != 0) begin n_bad++; $display("FAIL done_ignore_activity: got %0d want 0", leaks); end
    n_cmp++; if (dropCount !== 16'd0) begin n_bad++; $display("FAIL done_ignore_dropCount: got %0d want 0", dropCount); end
    pxReady = 1'b0;
    pulse_start();
    dOutValid = 1'b1; dOut = pix(50);
    @(negedge clk_fast);
    dOutValid = 1'b0;
    n_cmp++; if ({pxValid, pxSof} !== 2'b11) begin n_bad++; $display("FAIL done_next_sof: got %b want 11", {pxValid, pxSof}); end
  endtask

  task automatic test_reset_drain();
    int leaks = 0;
    pxReady = 1'b0;
    pulse_start();
    for (int i = 0; i < 8; i++) begin
      dOutValid = 1'b1; dOut = pix(60 + i);
      @(negedge clk_fast);
    end
    dOutValid = 1'b0;
    @(negedge clk_fast);
    n_cmp++; if (pxValid !== 1'b1) begin n_bad++; $display("FAIL rstdrain_pre_valid: got %b want 1", pxValid); end
    #2 rst_n = 1'b0;
    #1;
    n_cmp++; if (pxValid !== 1'b0) begin n_bad++; $display("FAIL rstdrain_pxValid: got %b want 0", pxValid); end
    n_cmp++; if (pxOut !== '0)     begin n_bad++; $display("FAIL rstdrain_pxOut: got %h want 0", pxOut); end
    n_cmp++; if ({pxSof, pxEol, frameDone, overflow} !== 4'b0)
      begin n_bad++; $display("FAIL rstdrain_flags: got %b want 0000", {pxSof, pxEol, frameDone, overflow}); end
    n_cmp++; if (dropCount !== 16'd0) begin n_bad++; $display("FAIL rstdrain_dropCount: got %0d want 0", dropCount); end
    @(negedge clk_fast);
    rst_n = 1'b1; pxReady = 1'b1;
    for (int c = 0; c < 12; c++) begin
      if (pxValid || frameDone) leaks++;
      dOutValid = 1'b1; dOut = pix(80 + c);
      @(negedge clk_fast);
    end
    dOutValid = 1'b0;
    n_cmp++; if (leaks != 0) begin n_bad++; $display("FAIL rstdrain_needs_start: got %0d active cycles want 0", leaks); end
  endtask

  initial begin
    test_reset();
    test_basic_frame();
    test_overflow();
    test_full_push_pop();
    test_restart();
    test_done_ignore();
    test_reset_drain();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, got timeout want completion");
    $fatal(1);
  end

endmodule
